alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for a shared combinational n-bit ALU (inputs a, b, 3-bit sel; outputs o, carry c).
- Accepts one operation at a time over a valid/ready handshake.
- Drives the ALU from registered operands and captures o/c one cycle later.
- Returns the result with the requester ID over a response valid/ready handshake.
- Sits between the control units and the single ALU instance in the datapath.

---
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter and sequencer for one shared
// combinational ALU. It accepts one operation at a time, drives the ALU
// from registered operands, captures the result one cycle later and
// returns it, tagged with the requester ID, over a valid/ready handshake.
// Only one operation is in flight at a time.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   reqX_valid/ready          request handshake (ready is combinational)
//   reqX_sel/a/b              requester operation
//   alu_sel/a/b               registered operands to the ALU
//   alu_o/alu_c               ALU result and carry
//   rsp_valid/ready           response handshake
//   rsp_id/o/c                issuing requester, captured result and carry
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win
// contention. The default build uses round-robin arbitration.
module alu_arbiter #(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_sel,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_sel,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    output logic [2:0]   alu_sel,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    input  logic [n-1:0] alu_o,
    input  logic         alu_c,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [n-1:0] rsp_o,
    output logic         rsp_c
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     alu_sel_q, alu_sel_d;
    logic [n-1:0]   alu_a_q, alu_a_d;
    logic [n-1:0]   alu_b_q, alu_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [n-1:0]   rsp_o_q, rsp_o_d;
    logic           rsp_c_q, rsp_c_d;
    logic           grant0, grant1;
    logic           idle_ok;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: the pointer never moves, so requester 0 always wins.
    logic rr_ptr_q;
    assign rr_ptr_q = 1'b0;
`else
    logic rr_ptr_q, rr_ptr_d;

    // After a response completes, favour the requester that was not served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == RESP && rsp_ready) begin
            rr_ptr_d = ~rsp_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Grants are only offered in IDLE and never while reset is asserted,
    // so the ready outputs read 0 during reset.
    assign idle_ok = (state_q == IDLE) && !rst;
    assign grant0  = idle_ok && req0_valid && (!req1_valid || !rr_ptr_q);
    assign grant1  = idle_ok && req1_valid && (!req0_valid ||  rr_ptr_q);

    always_comb begin
        state_d     = state_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_o_d     = rsp_o_q;
        rsp_c_d     = rsp_c_q;
        unique case (state_q)
            IDLE: begin
                if (grant0) begin
                    alu_sel_d = req0_sel;
                    alu_a_d   = req0_a;
                    alu_b_d   = req0_b;
                    rsp_id_d  = 1'b0;
                    state_d   = EXEC;
                end else if (grant1) begin
                    alu_sel_d = req1_sel;
                    alu_a_d   = req1_a;
                    alu_b_d   = req1_b;
                    rsp_id_d  = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // ALU has had one full cycle to settle on the registered operands.
                rsp_o_d     = alu_o;
                rsp_c_d     = alu_c;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_o_q     <= '0;
            rsp_c_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_o_q     <= rsp_o_d;
            rsp_c_q     <= rsp_c_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_sel    = alu_sel_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_o      = rsp_o_q;
    assign rsp_c      = rsp_c_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with a stub adder ALU (o = a+b mod 2^n,
// c = carry-out, sel ignored). Inputs change 1 time unit after the rising
// edge; outputs are observed on the falling edge.
module tb_alu_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic         id;
        logic         c;
        logic [N-1:0] o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [2:0]   req0_sel;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [2:0]   req1_sel;
    logic [N-1:0] req1_a, req1_b;
    logic [2:0]   alu_sel;
    logic [N-1:0] alu_a, alu_b, alu_o;
    logic         alu_c;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_c;
    logic [N-1:0] rsp_o;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    exp_t        sb[$];
    bit          grant_q[$];

    always #5 clk = ~clk;

    // Stub ALU.
    assign {alu_c, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};

    alu_arbiter #(.n(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sel   (req0_sel),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sel   (req1_sel),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_o      (alu_o),
        .alu_c      (alu_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_o      (rsp_o),
        .rsp_c      (rsp_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic id, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        exp_t       e;
        s    = {1'b0, a} + {1'b0, b};
        e.id = id;
        e.c  = s[N];
        e.o  = s[N-1:0];
        return e;
    endfunction

    // Scoreboard: push on acceptance, pop on response handshake.
    always @(negedge clk) begin
        exp_t e;
        chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (rst) begin
            sb.delete();
        end else begin
            if (req0_ready) begin
                sb.push_back(mk_exp(1'b0, req0_a, req0_b));
                grant_q.push_back(1'b0);
            end else if (req1_ready) begin
                sb.push_back(mk_exp(1'b1, req1_a, req1_b));
                grant_q.push_back(1'b1);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                    chk("rsp_o", {28'd0, rsp_o}, {28'd0, e.o});
                    chk("rsp_c", {31'd0, rsp_c}, {31'd0, e.c});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned g0;
        bit          done;

        // Reset with a pending request.
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_sel = 3'b000; req0_a = 4'd3; req0_b = 4'd4;
        req1_valid = 1'b0; req1_sel = 3'b000; req1_a = '0;   req1_b = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {28'd0, alu_b}, 32'd0);
        chk("rst_alu_sel", {29'd0, alu_sel}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_o", {28'd0, rsp_o}, 32'd0);
        chk("rst_rsp_c", {31'd0, rsp_c}, 32'd0);
        chk("rst_state", {30'd0, dut.state_q}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single request: accepted in the first IDLE cycle.
        @(negedge clk);
        chk("first_idle_ready0", {31'd0, req0_ready}, 32'd1);
        chk("first_idle_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("exec_state", {30'd0, dut.state_q}, 32'd1);
        chk("exec_alu_a", {28'd0, alu_a}, 32'd3);
        chk("exec_alu_b", {28'd0, alu_b}, 32'd4);
        chk("exec_alu_sel", {29'd0, alu_sel}, 32'd0);
        chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t2_rsp_o", {28'd0, rsp_o}, 32'd7);
        chk("t2_rsp_c", {31'd0, rsp_c}, 32'd0);
        @(negedge clk);
        chk("post_hs_state", {30'd0, dut.state_q}, 32'd0);
        chk("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset during EXEC aborts the operation.
        @(posedge clk); #1 req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd6; req0_sel = 3'b101;
        @(negedge clk);
        chk("midop_ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1 req0_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midop_in_exec", {30'd0, dut.state_q}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midop_state", {30'd0, dut.state_q}, 32'd0);
        chk("midop_alu_sel", {29'd0, alu_sel}, 32'd0);
        repeat (4) @(negedge clk);
        chk("midop_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // Contention: both valid continuously, rr_ptr starts at 0 after reset.
        g0 = grant_q.size();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_sel = 3'b000;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd8; req1_sel = 3'b010;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            if (grant_q.size() >= g0 + 4) begin
                done = 1'b1;
                break;
            end
        end
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        chk("contention_done", {31'd0, done}, 32'd1);
        if (done) begin
            for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                chk("grant_order", {31'd0, grant_q[g0 + i]}, 32'd0);
`else
                chk("grant_order", {31'd0, grant_q[g0 + i]}, i % 2);
`endif
            end
        end

        // Drain the in-flight operation.
        done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!rsp_valid && dut.state_q == 2'd0 && !req0_ready && !req1_ready) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", {31'd0, done}, 32'd1);

        // Backpressure: response held while rsp_ready is low.
        rsp_ready = 1'b0;
        @(posedge clk); #1 req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd8; req1_sel = 3'b011;
        done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("bp_rsp_seen", {31'd0, done}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 req0_valid = 1'b1;
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_id", {31'd0, rsp_id}, 32'd1);
            chk("bp_rsp_o", {28'd0, rsp_o}, 32'd1);
            chk("bp_rsp_c", {31'd0, rsp_c}, 32'd1);
            chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
            chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_after_state", {30'd0, dut.state_q}, 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
